countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 151 +++++++++++++++
 tb/tb_countdown_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown timer driven by an external one-second tick.
// Supports load validation, pause/resume, expiry and optional auto-reload.
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        tick,
  input  logic        load,
  input  logic        start,
  input  logic        pause,
  input  logic [23:0] timeBitsIn,
  output logic [23:0] timeBitsOut,
  output logic [1:0]  timerState,
  output logic        done,
  output logic        expired,
  output logic        loadError
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } timerStateT;

  timerStateT  stateR, stateNext;
  logic [23:0] countR, countNext;
  logic [23:0] reloadR, reloadNext;
  logic        doneR, doneNext;
  logic        loadErrorR, loadErrorNext;
  logic        expiredR;

  // Hours are capped at 23, so the hours-tens digit is checked together with the units.
  function automatic logic isValidBcd(input logic [23:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
           (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
           (t[19:16] <= 4'd9) && (t[23:20] <= 4'd2) &&
           !((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
  endfunction

  // Ripple borrow from seconds upward; only called with a non-zero count.
  function automatic logic [23:0] decBcd(input logic [23:0] t);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  maxDigit;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      maxDigit = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = maxDigit;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        borrow = 1'b0;
      end
    end
    return r;
  endfunction

  // Next-state logic with priority load > pause > start > tick.
  always_comb begin
    countNext     = countR;
    reloadNext    = reloadR;
    stateNext     = stateR;
    doneNext      = 1'b0;
    loadErrorNext = 1'b0;
    if (load) begin
      if (isValidBcd(timeBitsIn)) begin
        countNext  = timeBitsIn;
        reloadNext = timeBitsIn;
        stateNext  = IDLE;
      end else begin
        loadErrorNext = 1'b1;
      end
    end else if (pause) begin
      if (stateR == RUN) begin
        stateNext = PAUSED;
      end else begin
        stateNext = stateR;
      end
    end else if (start && (stateR != RUN)) begin
      case (stateR)
        IDLE: begin
          if (countR != 24'h000000) begin
            stateNext = RUN;
          end else begin
            stateNext = IDLE;
          end
        end
        PAUSED: stateNext = RUN;
        EXPIRED: begin
          if (reloadR != 24'h000000) begin
            countNext = reloadR;
            stateNext = RUN;
          end else begin
            stateNext = EXPIRED;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (tick && (stateR == RUN)) begin
      if (countR == 24'h000001) begin
        doneNext = 1'b1;
        if (AUTO_RELOAD) begin
          countNext = reloadR;
        end else begin
          countNext = 24'h000000;
          stateNext = EXPIRED;
        end
      end else if (countR == 24'h000000) begin
        stateNext = EXPIRED;
      end else begin
        countNext = decBcd(countR);
      end
    end else begin
      stateNext = stateR;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateR     <= IDLE;
      countR     <= 24'h000000;
      reloadR    <= 24'h000000;
      doneR      <= 1'b0;
      loadErrorR <= 1'b0;
      expiredR   <= 1'b0;
    end else begin
      stateR     <= stateNext;
      countR     <= countNext;
      reloadR    <= reloadNext;
      doneR      <= doneNext;
      loadErrorR <= loadErrorNext;
      expiredR   <= (stateNext == EXPIRED);
    end
  end

  assign timeBitsOut = countR;
  assign timerState  = stateR;
  assign done        = doneR;
  assign expired     = expiredR;
  assign loadError   = loadErrorR;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-based model checks both AUTO_RELOAD
// variants every cycle, plus hand-computed literal expectations.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        tick, load, start, pause;
  logic [23:0] timeBitsIn;

  logic [23:0] tOut[2];
  logic [1:0]  tState[2];
  logic        tDone[2], tExp[2], tLdErr[2];

  int checks = 0;
  int errors = 0;

  int mSecs[2], mReload[2], mState[2];
  bit mDone[2], mLdErr[2];

  countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .resetN(resetN), .tick(tick), .load(load), .start(start), .pause(pause),
    .timeBitsIn(timeBitsIn), .timeBitsOut(tOut[0]), .timerState(tState[0]),
    .done(tDone[0]), .expired(tExp[0]), .loadError(tLdErr[0])
  );

  countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .resetN(resetN), .tick(tick), .load(load), .start(start), .pause(pause),
    .timeBitsIn(timeBitsIn), .timeBitsOut(tOut[1]), .timerState(tState[1]),
    .done(tDone[1]), .expired(tExp[1]), .loadError(tLdErr[1])
  );

  always #5 clk = ~clk;

  function automatic int digitOf(input logic [23:0] v, input int i);
    logic [23:0] t;
    t = v >> (4 * i);
    return int'(t[3:0]);
  endfunction

  function automatic bit isValid(input logic [23:0] v);
    return digitOf(v, 0) <= 9 && digitOf(v, 1) <= 5 && digitOf(v, 2) <= 9 &&
           digitOf(v, 3) <= 5 && digitOf(v, 4) <= 9 &&
           (digitOf(v, 5) * 10 + digitOf(v, 4)) < 24;
  endfunction

  function automatic int toSecs(input logic [23:0] v);
    return (digitOf(v, 5) * 10 + digitOf(v, 4)) * 3600 +
           (digitOf(v, 3) * 10 + digitOf(v, 2)) * 60 +
           (digitOf(v, 1) * 10 + digitOf(v, 0));
  endfunction

  function automatic logic [23:0] toBcd(input int s);
    int h, m, sec;
    h   = s / 3600;
    m   = (s / 60) % 60;
    sec = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model in whole seconds; index 1 is the auto-reload variant.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        mSecs[i] <= 0; mReload[i] <= 0; mState[i] <= 0; mDone[i] <= 1'b0; mLdErr[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mDone[i]  <= 1'b0;
        mLdErr[i] <= 1'b0;
        if (load) begin
          if (isValid(timeBitsIn)) begin
            mSecs[i]   <= toSecs(timeBitsIn);
            mReload[i] <= toSecs(timeBitsIn);
            mState[i]  <= 0;
          end else begin
            mLdErr[i] <= 1'b1;
          end
        end else if (pause) begin
          if (mState[i] == 1) mState[i] <= 2;
        end else if (start && mState[i] != 1) begin
          if (mState[i] == 0 && mSecs[i] > 0) mState[i] <= 1;
          else if (mState[i] == 2) mState[i] <= 1;
          else if (mState[i] == 3 && mReload[i] > 0) begin
            mSecs[i]  <= mReload[i];
            mState[i] <= 1;
          end
        end else if (tick && mState[i] == 1) begin
          if (mSecs[i] == 1) begin
            mDone[i] <= 1'b1;
            if (i == 1) mSecs[i] <= mReload[i];
            else begin
              mSecs[i]  <= 0;
              mState[i] <= 3;
            end
          end else begin
            mSecs[i] <= mSecs[i] - 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[%0d]", i), tOut[i], toBcd(mSecs[i]));
      chk($sformatf("state[%0d]", i), tState[i], mState[i][1:0]);
      chk($sformatf("done[%0d]", i), tDone[i], mDone[i]);
      chk($sformatf("expired[%0d]", i), tExp[i], (mState[i] == 3));
      chk($sformatf("loadError[%0d]", i), tLdErr[i], mLdErr[i]);
    end
  end

  task automatic step(input bit ld, input bit st, input bit pa, input bit tk, input logic [23:0] v);
    load = ld; start = st; pause = pa; tick = tk; timeBitsIn = v;
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; timeBitsIn = 24'h000000;
    repeat (2) @(negedge clk);
    chk("rst count", tOut[0], 24'h000000);
    chk("rst state", tState[0], 2'b00);
    chk("rst flags", {tDone[0], tExp[0], tLdErr[0]}, 3'b000);
    resetN = 1'b1;

    // One minute countdown to expiry
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000100);
    chk("load 000100", tOut[0], 24'h000100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("start run", tState[0], 2'b01);
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("59 ticks", tOut[0], 24'h000001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("expire count", tOut[0], 24'h000000);
    chk("expire done", tDone[0], 1'b1);
    chk("expire state", tState[0], 2'b11);
    chk("expire level", tExp[0], 1'b1);
    chk("reload count", tOut[1], 24'h000100);
    chk("reload state", tState[1], 2'b01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("done pulse end", tDone[0], 1'b0);
    chk("expired hold", tOut[0], 24'h000000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("restart reload", tOut[0], 24'h000100);
    chk("restart state", tState[0], 2'b01);

    // Hour borrows
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h100000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("10h borrow", tOut[0], 24'h095959);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h200000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("20h borrow", tOut[0], 24'h195959);

    // Rejected loads while running
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h240000);
    chk("bad 24h err", tLdErr[0], 1'b1);
    chk("bad 24h count", tOut[0], 24'h195959);
    chk("bad 24h state", tState[0], 2'b01);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h006000);
    chk("bad 60m err", tLdErr[0], 1'b1);
    chk("bad 60m count", tOut[0], 24'h195959);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    chk("err pulse end", tLdErr[0], 1'b0);

    // Largest valid value
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h235959);
    chk("load 235959", tOut[0], 24'h235959);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("235959 tick", tOut[0], 24'h235958);

    // Pause wins over a same-cycle tick
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    chk("pause state", tState[0], 2'b10);
    chk("pause count", tOut[0], 24'h000010);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("paused hold", tOut[0], 24'h000010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("resume", tState[0], 2'b01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("resume tick", tOut[0], 24'h000009);

    // IDLE ignores pause, and start with zero count
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000005);
    step(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
    chk("idle pause", tState[0], 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("idle zero start", tState[0], 2'b00);

    // Auto-reload after three seconds
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000003);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("ar done", tDone[1], 1'b1);
    chk("ar count", tOut[1], 24'h000003);
    chk("ar state", tState[1], 2'b01);
    chk("no-ar state", tState[0], 2'b11);

    // Asynchronous reset mid-count
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h123456);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("pre-reset count", tOut[0], 24'h123455);
    #2;
    resetN = 1'b0;
    #1;
    chk("async rst count", tOut[0], 24'h000000);
    chk("async rst state", tState[0], 2'b00);
    chk("async rst flags", {tDone[0], tExp[0], tLdErr[0]}, 3'b000);
    chk("async rst ar count", tOut[1], 24'h000000);
    @(negedge clk);
    resetN = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    chk("post-rst start", tState[0], 2'b00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
    chk("post-rst count", tOut[0], 24'h000000);

    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
